gc_response_rx: RTL and testbench

Receiver for the GameCube controller single-wire bus, sitting between the bus pad and the controller-state logic. After the query sender releases the line (`send` falls), it decodes the controller's reply bit by bit. It then presents either the 24-bit status/ID word or the 64-bit button report, each with a one-cycle ready pulse. These pulses are the `wavebird_id_ready` / `button_data_ready` inputs that the state logic uses for init sequencing and its 1 s response watchdog.

---
 rtl/gc_pkg.sv | 23 ++
 rtl/gc_line_sync.sv | 30 +++
 rtl/gc_response_rx.sv | 172 +++++++++++++++++
 tb/tb_gc_response_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared constants and types for the GameCube controller bus blocks.
package gc_pkg;

  localparam int unsigned GC_ID_BITS     = 24;
  localparam int unsigned GC_BUTTON_BITS = 64;
  localparam int unsigned GC_SHREG_BITS  = GC_BUTTON_BITS + 1;
  localparam int unsigned GC_BITCNT_W    = 7;
  localparam int unsigned GC_CNT_W       = 16;

  // Default bus timing at 100 MHz, shared with the query sender.
  localparam int unsigned GC_SAMPLE_CYCLES = 200;
  localparam int unsigned GC_END_CYCLES    = 600;
  localparam int unsigned GC_RESP_CYCLES   = 20000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_ARMED,
    ST_BIT,
    ST_GAP
  } gc_rx_state_e;

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the bus line with falling-edge detect.
module gc_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_async,
  output logic line_q,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset high so the idle pulled-up line never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_q = sync_q;
  assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/gc_response_rx.sv
// Decodes a controller reply into the status/ID word or the button report.
module gc_response_rx
  import gc_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = GC_SAMPLE_CYCLES,
  parameter int unsigned END_CYCLES    = GC_END_CYCLES,
  parameter int unsigned RESP_CYCLES   = GC_RESP_CYCLES
) (
  input  logic                      clk100mhz,
  input  logic                      rst_n,
  input  logic                      controller_data,
  input  logic                      send,
  output logic [GC_ID_BITS-1:0]     wavebird_id,
  output logic                      wavebird_id_ready,
  output logic [GC_BUTTON_BITS-1:0] button_data,
  output logic                      button_data_ready,
  output logic                      frame_error,
  output logic                      busy
);

  localparam logic [GC_BITCNT_W-1:0] BITS_ID  = GC_BITCNT_W'(GC_ID_BITS + 1);
  localparam logic [GC_BITCNT_W-1:0] BITS_BTN = GC_BITCNT_W'(GC_BUTTON_BITS + 1);
  localparam logic [GC_CNT_W-1:0]    CNT_SAMPLE = GC_CNT_W'(SAMPLE_CYCLES);
  localparam logic [GC_CNT_W-1:0]    CNT_END    = GC_CNT_W'(END_CYCLES - 1);
  localparam logic [GC_CNT_W-1:0]    CNT_RESP   = GC_CNT_W'(RESP_CYCLES - 1);

  logic line_q;
  logic fall_c;

  gc_rx_state_e                state_q,   state_d;
  logic [GC_CNT_W-1:0]         cnt_q,     cnt_d;
  logic [GC_BITCNT_W-1:0]      bits_q,    bits_d;
  logic [GC_SHREG_BITS-1:0]    shreg_q,   shreg_d;
  logic [GC_ID_BITS-1:0]       id_q,      id_d;
  logic [GC_BUTTON_BITS-1:0]   btn_q,     btn_d;
  logic                        id_rdy_q,  id_rdy_d;
  logic                        btn_rdy_q, btn_rdy_d;
  logic                        err_q,     err_d;
  logic                        busy_q,    busy_d;
  logic [GC_CNT_W-1:0]         cnt_inc_c;

  gc_line_sync u_line_sync (
    .clk        (clk100mhz),
    .rst_n      (rst_n),
    .line_async (controller_data),
    .line_q     (line_q),
    .fall_c     (fall_c)
  );

  // Saturating cycle counter increment; cnt_q holds cycles since the last edge.
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + GC_CNT_W'(1);

  // Next-state, bit capture and frame-close decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    btn_d     = btn_q;
    id_rdy_d  = 1'b0;
    btn_rdy_d = 1'b0;
    err_d     = 1'b0;
    // Lags the state by one so busy drops the cycle after the close pulse.
    busy_d    = (state_q == ST_ARMED) || (state_q == ST_BIT) || (state_q == ST_GAP);

    unique case (state_q)
      ST_IDLE: begin
        if (send) state_d = ST_TX;
      end

      ST_TX: begin
        if (!send) begin
          state_d = ST_ARMED;
          cnt_d   = GC_CNT_W'(1);
          bits_d  = '0;
          shreg_d = '0;
        end
      end

      ST_ARMED: begin
        if (send) begin
          err_d   = 1'b1;
          state_d = ST_TX;
        end else if (fall_c) begin
          state_d = ST_BIT;
          cnt_d   = GC_CNT_W'(1);
        end else if (cnt_q >= CNT_RESP) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      ST_BIT: begin
        if (send) begin
          err_d   = 1'b1;
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_q >= CNT_SAMPLE) begin
            shreg_d = {shreg_q[GC_SHREG_BITS-2:0], line_q};
            if (bits_q != '1) bits_d = bits_q + GC_BITCNT_W'(1);
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (send) begin
          err_d   = 1'b1;
          state_d = ST_TX;
        end else if (fall_c) begin
          state_d = ST_BIT;
          cnt_d   = GC_CNT_W'(1);
        end else if (cnt_q >= CNT_END) begin
          state_d = ST_IDLE;
          // A line still low here is a stuck bus, regardless of bit count.
          if (line_q && bits_q == BITS_ID && shreg_q[0]) begin
            id_d     = shreg_q[GC_ID_BITS:1];
            id_rdy_d = 1'b1;
          end else if (line_q && bits_q == BITS_BTN && shreg_q[0]) begin
            btn_d     = shreg_q[GC_BUTTON_BITS:1];
            btn_rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      shreg_q   <= '0;
      id_q      <= '0;
      btn_q     <= '0;
      id_rdy_q  <= 1'b0;
      btn_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shreg_q   <= shreg_d;
      id_q      <= id_d;
      btn_q     <= btn_d;
      id_rdy_q  <= id_rdy_d;
      btn_rdy_q <= btn_rdy_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign wavebird_id       = id_q;
  assign wavebird_id_ready = id_rdy_q;
  assign button_data       = btn_q;
  assign button_data_ready = btn_rdy_q;
  assign frame_error       = err_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed bench for gc_response_rx with timing scaled down by 10.
module tb_gc_response_rx;

  localparam int unsigned S = 20;
  localparam int unsigned E = 60;
  localparam int unsigned R = 2000;

  logic        clk100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        controller_data = 1'b1;
  logic        send = 1'b0;
  logic [23:0] wavebird_id;
  logic        wavebird_id_ready;
  logic [63:0] button_data;
  logic        button_data_ready;
  logic        frame_error;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int id_cnt = 0, btn_cnt = 0, err_cnt = 0, multi_cnt = 0;
  int s_id = 0, s_btn = 0, s_err = 0;
  int lat;
  int waited;

  gc_response_rx #(
    .SAMPLE_CYCLES (S),
    .END_CYCLES    (E),
    .RESP_CYCLES   (R)
  ) dut (
    .clk100mhz         (clk100mhz),
    .rst_n             (rst_n),
    .controller_data   (controller_data),
    .send              (send),
    .wavebird_id       (wavebird_id),
    .wavebird_id_ready (wavebird_id_ready),
    .button_data       (button_data),
    .button_data_ready (button_data_ready),
    .frame_error       (frame_error),
    .busy              (busy)
  );

  always #5 clk100mhz = ~clk100mhz;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk100mhz) begin
    id_cnt  += int'(wavebird_id_ready);
    btn_cnt += int'(button_data_ready);
    err_cnt += int'(frame_error);
    if (int'(wavebird_id_ready) + int'(button_data_ready) + int'(frame_error) > 1)
      multi_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic snap();
    s_id  = id_cnt;
    s_btn = btn_cnt;
    s_err = err_cnt;
  endtask

  task automatic check_deltas(input string tag, input int di, input int db, input int de);
    check({tag, "_id_pulses"},  64'(id_cnt - s_id),   64'(di));
    check({tag, "_btn_pulses"}, 64'(btn_cnt - s_btn), 64'(db));
    check({tag, "_err_pulses"}, 64'(err_cnt - s_err), 64'(de));
  endtask

  // 1 bit: 10 low / 30 high; 0 bit: 30 low / 10 high.
  task automatic drive_bit(input logic b);
    controller_data = 1'b0;
    repeat (b ? 10 : 30) tick();
    controller_data = 1'b1;
    repeat (b ? 30 : 10) tick();
  endtask

  // Query phase; line wiggles while send is high and must be ignored.
  task automatic do_send();
    send = 1'b1;
    repeat (3) tick();
    repeat (3) begin
      controller_data = 1'b0;
      repeat (5) tick();
      controller_data = 1'b1;
      repeat (5) tick();
    end
    send = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(w[i]);
  endtask

  // Stop bit, then count cycles until a close pulse is visible.
  task automatic stop_close(output int l);
    controller_data = 1'b0;
    l = 0;
    while (l < int'(E) + 40) begin
      tick();
      l++;
      if (l == 10) controller_data = 1'b1;
      if (wavebird_id_ready || button_data_ready || frame_error) break;
    end
    controller_data = 1'b1;
  endtask

  task automatic wait_close(input int budget, output int w);
    w = 0;
    while (w < budget && !(wavebird_id_ready || button_data_ready || frame_error)) begin
      tick();
      w++;
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_id",      64'(wavebird_id), 64'h0);
    check("rst_btn",     button_data, 64'h0);
    check("rst_id_rdy",  64'(wavebird_id_ready), 64'h0);
    check("rst_btn_rdy", 64'(button_data_ready), 64'h0);
    check("rst_err",     64'(frame_error), 64'h0);
    check("rst_busy",    64'(busy), 64'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Wavebird status reply
    snap();
    do_send();
    send_word(64'hA80000, 24);
    check("wb_busy_mid", 64'(busy), 64'h1);
    stop_close(lat);
    check("wb_latency", 64'(lat), 64'(E + 2));
    check("wb_id", 64'(wavebird_id), 64'hA80000);
    check("wb_busy_at_pulse", 64'(busy), 64'h1);
    tick();
    check("wb_busy_after", 64'(busy), 64'h0);
    repeat (5) tick();
    check_deltas("wb", 1, 0, 0);

    // Wired controller status reply
    snap();
    do_send();
    send_word(64'h090000, 24);
    stop_close(lat);
    check("wired_latency", 64'(lat), 64'(E + 2));
    check("wired_id", 64'(wavebird_id), 64'h090000);
    repeat (5) tick();
    check_deltas("wired", 1, 0, 0);

    // Poll reply
    snap();
    do_send();
    send_word(64'h0080_7F80_8020_2000, 64);
    stop_close(lat);
    check("poll_latency", 64'(lat), 64'(E + 2));
    check("poll_btn", button_data, 64'h0080_7F80_8020_2000);
    check("poll_id_hold", 64'(wavebird_id), 64'h090000);
    repeat (5) tick();
    check_deltas("poll", 0, 1, 0);

    // No reply
    snap();
    do_send();
    wait_close(int'(R) + 100, waited);
    check("noresp_in_time", 64'(waited < int'(R) + 100), 64'h1);
    tick();
    check("noresp_busy", 64'(busy), 64'h0);
    check("noresp_id_hold", 64'(wavebird_id), 64'h090000);
    check("noresp_btn_hold", button_data, 64'h0080_7F80_8020_2000);
    repeat (5) tick();
    check_deltas("noresp", 0, 0, 1);

    // Truncated 20-bit reply
    snap();
    do_send();
    send_word(64'hA5A5A, 20);
    wait_close(int'(E) + 20, waited);
    check("trunc_in_time", 64'(waited < int'(E) + 20), 64'h1);
    repeat (5) tick();
    check_deltas("trunc", 0, 0, 1);

    // 25-bit reply with stop bit 0
    snap();
    do_send();
    send_word(64'h150_0000, 25);
    wait_close(int'(E) + 20, waited);
    repeat (5) tick();
    check_deltas("stop0", 0, 0, 1);
    check("stop0_id_hold", 64'(wavebird_id), 64'h090000);

    // Line stuck low for 70 cycles
    snap();
    do_send();
    controller_data = 1'b0;
    repeat (70) tick();
    controller_data = 1'b1;
    repeat (E + 20) tick();
    check_deltas("stuck", 0, 0, 1);

    // Abort after 10 bits, then a valid reply
    snap();
    do_send();
    send_word(64'h2AA, 10);
    do_send();
    check_deltas("abort", 0, 0, 1);
    send_word(64'h123456, 24);
    stop_close(lat);
    check("abort_reply_latency", 64'(lat), 64'(E + 2));
    check("abort_reply_id", 64'(wavebird_id), 64'h123456);
    repeat (5) tick();
    check_deltas("abort_reply", 1, 0, 1);

    // Reset mid-frame
    snap();
    do_send();
    send_word(64'hF0, 8);
    controller_data = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_id", 64'(wavebird_id), 64'h0);
    check("midrst_btn", button_data, 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_pulses", 64'({wavebird_id_ready, button_data_ready, frame_error}), 64'h0);
    controller_data = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (E + 40) tick();
    check_deltas("midrst", 0, 0, 0);
    check("midrst_id_after", 64'(wavebird_id), 64'h0);

    check("one_pulse_per_cycle", 64'(multi_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
